// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and the instruction memory or cache (slave).
interface fetch_unit_if;
  logic        imem_read;
  logic [31:0] imem_address;
  logic        imem_resp;
  logic [31:0] imem_rdata;

  modport master (
    output imem_read,
    output imem_address,
    input  imem_resp,
    input  imem_rdata
  );

  modport slave (
    input  imem_read,
    input  imem_address,
    output imem_resp,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Pipeline IF stage: issues instruction fetches, fills the IF/ID register,
// parks one word while the pipe is stalled, and redirects on branch events.
module fetch_unit (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                mispredict,
  input  logic [31:0]         ex_target,
  input  logic                sbp_mux_sel,
  input  logic [31:0]         sbp_target,
  fetch_unit_if.master        imem,
  output logic [31:0]         IF_ID_pc_out,
  output logic [31:0]         IF_ID_ir_out,
  output logic                IF_ID_invalidate_out,
  output logic [6:0]          opcode
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC = 32'h0000_0060;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] redirect;
  logic [31:0] buf_pc;
  logic [31:0] buf_ir;
  logic [31:0] next_pc;

  // The ID-stage predictor only speaks for a real instruction sitting in IF/ID.
  assign next_pc           = (sbp_mux_sel && !IF_ID_invalidate_out) ? sbp_target
                                                                    : pc + 32'd4;
  assign imem.imem_address = pc;
  assign opcode            = IF_ID_ir_out[6:0];

  // NOTE: every register here updates with <= so all branches see the
  // pre-edge values of pc, state and IF_ID_invalidate_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= FETCH;
      pc                   <= RESET_PC;
      redirect             <= '0;
      buf_pc               <= '0;
      buf_ir               <= '0;
      imem.imem_read       <= 1'b0;
      IF_ID_pc_out         <= '0;
      IF_ID_ir_out         <= NOP_WORD;
      IF_ID_invalidate_out <= 1'b1;
    end else begin
      imem.imem_read <= 1'b1;
      case (state)
        FETCH: begin
          if (mispredict) begin
            IF_ID_invalidate_out <= 1'b1;
            if (imem.imem_resp) begin
              pc <= ex_target;
            end else begin
              redirect <= ex_target;
              state    <= DRAIN;
            end
          end else if (imem.imem_resp) begin
            pc <= next_pc;
            if (stall) begin
              buf_pc         <= pc;
              buf_ir         <= imem.imem_rdata;
              state          <= FULL;
              imem.imem_read <= 1'b0;
            end else begin
              IF_ID_pc_out         <= pc;
              IF_ID_ir_out         <= imem.imem_rdata;
              IF_ID_invalidate_out <= 1'b0;
            end
          end else if (!stall) begin
            IF_ID_invalidate_out <= 1'b1;
          end
        end

        FULL: begin
          if (mispredict) begin
            pc                   <= ex_target;
            IF_ID_invalidate_out <= 1'b1;
            state                <= FETCH;
          end else if (!stall) begin
            IF_ID_pc_out         <= buf_pc;
            IF_ID_ir_out         <= buf_ir;
            IF_ID_invalidate_out <= 1'b0;
            state                <= FETCH;
          end else begin
            imem.imem_read <= 1'b0;
          end
        end

        DRAIN: begin
          if (mispredict) begin
            redirect             <= ex_target;
            IF_ID_invalidate_out <= 1'b1;
          end
          // A redirect arriving with the stale response wins over the older one.
          if (imem.imem_resp) begin
            pc    <= mispredict ? ex_target : redirect;
            state <= FETCH;
          end
        end

        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, reset corner sequence, and a
// randomized run against a transaction-level model of the fetch stage.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        mispredict;
  logic [31:0] ex_target;
  logic        sbp_mux_sel;
  logic [31:0] sbp_target;
  logic [31:0] IF_ID_pc_out;
  logic [31:0] IF_ID_ir_out;
  logic        IF_ID_invalidate_out;
  logic [6:0]  opcode;

  fetch_unit_if imem_bus ();

  fetch_unit dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .stall                (stall),
    .mispredict           (mispredict),
    .ex_target            (ex_target),
    .sbp_mux_sel          (sbp_mux_sel),
    .sbp_target           (sbp_target),
    .imem                 (imem_bus.master),
    .IF_ID_pc_out         (IF_ID_pc_out),
    .IF_ID_ir_out         (IF_ID_ir_out),
    .IF_ID_invalidate_out (IF_ID_invalidate_out),
    .opcode               (opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic mis, input logic [31:0] ex,
                       input logic sbp, input logic [31:0] sbpt,
                       input logic resp, input logic [31:0] rdata);
    stall               = st;
    mispredict          = mis;
    ex_target           = ex;
    sbp_mux_sel         = sbp;
    sbp_target          = sbpt;
    imem_bus.imem_resp  = resp;
    imem_bus.imem_rdata = rdata;
  endtask

  task automatic check_outputs(input string tag, input logic e_read, input logic [31:0] e_addr,
                               input logic [31:0] e_pc, input logic [31:0] e_ir, input logic e_inv);
    logic [31:0] ir_tmp;
    ir_tmp = e_ir;
    check({tag, ".imem_read"},    {31'd0, imem_bus.imem_read}, {31'd0, e_read});
    check({tag, ".imem_address"}, imem_bus.imem_address, e_addr);
    check({tag, ".if_id_pc"},     IF_ID_pc_out, e_pc);
    check({tag, ".if_id_ir"},     IF_ID_ir_out, e_ir);
    check({tag, ".invalidate"},   {31'd0, IF_ID_invalidate_out}, {31'd0, e_inv});
    check({tag, ".opcode"},       {25'd0, opcode}, {25'd0, ir_tmp[6:0]});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        stall;
    logic        mis;
    logic [31:0] ex;
    logic        sbp;
    logic [31:0] sbpt;
    logic        resp;
    logic [31:0] rdata;
    logic        e_read;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_ir;
    logic        e_inv;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] W_A = 32'h00A0_0093, W_B = 32'h00B0_0113, W_C = 32'h0000_0C37;
  localparam logic [31:0] W_D = 32'h0000_0D6F, W_E = 32'h00E0_0193, W_F = 32'hDEAD_BEEF;
  localparam logic [31:0] W_G = 32'h0120_0213, W_H = 32'h0000_0317, W_I = 32'h0140_0293;
  localparam logic [31:0] W_J = 32'hBAD0_0003, W_K = 32'hBAD1_0003, W_L = 32'h0160_0313;
  localparam logic [31:0] W_M = 32'h0180_0393;

  task automatic fill_table();
    //            stall mis ex            sbp sbpt          resp rdata  read addr          pc            ir         inv
    vecs.push_back('{0, 0, 32'h0,         0, 32'h0,         0, 32'h0, 1, 32'h0000_0060, 32'h0,         32'h13, 1});
    vecs.push_back('{0, 0, 32'h0,         0, 32'h0,         1, W_A,   1, 32'h0000_0064, 32'h0000_0060, W_A,    0});
    vecs.push_back('{0, 0, 32'h0,         0, 32'h0,         1, W_B,   1, 32'h0000_0068, 32'h0000_0064, W_B,    0});
    vecs.push_back('{1, 0, 32'h0,         0, 32'h0,         1, W_C,   0, 32'h0000_006C, 32'h0000_0064, W_B,    0});
    vecs.push_back('{1, 0, 32'h0,         0, 32'h0,         0, 32'h0, 0, 32'h0000_006C, 32'h0000_0064, W_B,    0});
    vecs.push_back('{1, 0, 32'h0,         0, 32'h0,         0, 32'h0, 0, 32'h0000_006C, 32'h0000_0064, W_B,    0});
    vecs.push_back('{0, 0, 32'h0,         0, 32'h0,         0, 32'h0, 1, 32'h0000_006C, 32'h0000_0068, W_C,    0});
    vecs.push_back('{0, 0, 32'h0,         1, 32'h100,       1, W_D,   1, 32'h0000_0100, 32'h0000_006C, W_D,    0});
    vecs.push_back('{0, 0, 32'h0,         1, 32'h300,       0, 32'h0, 1, 32'h0000_0100, 32'h0000_006C, W_D,    1});
    vecs.push_back('{0, 0, 32'h0,         1, 32'h300,       1, W_E,   1, 32'h0000_0104, 32'h0000_0100, W_E,    0});
    vecs.push_back('{0, 1, 32'h200,       0, 32'h0,         0, 32'h0, 1, 32'h0000_0104, 32'h0000_0100, W_E,    1});
    vecs.push_back('{0, 0, 32'h0,         0, 32'h0,         1, W_F,   1, 32'h0000_0200, 32'h0000_0100, W_E,    1});
    vecs.push_back('{0, 0, 32'h0,         0, 32'h0,         1, W_G,   1, 32'h0000_0204, 32'h0000_0200, W_G,    0});
    vecs.push_back('{1, 0, 32'h0,         0, 32'h0,         1, W_H,   0, 32'h0000_0208, 32'h0000_0200, W_G,    0});
    vecs.push_back('{1, 1, 32'h400,       0, 32'h0,         0, 32'h0, 1, 32'h0000_0400, 32'h0000_0200, W_G,    1});
    vecs.push_back('{0, 0, 32'h0,         0, 32'h0,         0, 32'h0, 1, 32'h0000_0400, 32'h0000_0200, W_G,    1});
    vecs.push_back('{0, 0, 32'h0,         0, 32'h0,         1, W_I,   1, 32'h0000_0404, 32'h0000_0400, W_I,    0});
    vecs.push_back('{0, 1, 32'h500,       0, 32'h0,         1, W_J,   1, 32'h0000_0500, 32'h0000_0400, W_I,    1});
    vecs.push_back('{0, 1, 32'hFFFF_FFFC, 0, 32'h0,         1, W_K,   1, 32'hFFFF_FFFC, 32'h0000_0400, W_I,    1});
    vecs.push_back('{0, 0, 32'h0,         0, 32'h0,         1, W_L,   1, 32'h0000_0000, 32'hFFFF_FFFC, W_L,    0});
    vecs.push_back('{0, 1, 32'h600,       0, 32'h0,         0, 32'h0, 1, 32'h0000_0000, 32'hFFFF_FFFC, W_L,    1});
    vecs.push_back('{0, 1, 32'h700,       0, 32'h0,         0, 32'h0, 1, 32'h0000_0000, 32'hFFFF_FFFC, W_L,    1});
    vecs.push_back('{0, 0, 32'h0,         0, 32'h0,         1, W_F,   1, 32'h0000_0700, 32'hFFFF_FFFC, W_L,    1});
    vecs.push_back('{0, 1, 32'h800,       0, 32'h0,         0, 32'h0, 1, 32'h0000_0700, 32'hFFFF_FFFC, W_L,    1});
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
  } slot_t;

  logic [31:0] m_pc;
  logic [31:0] m_redirect;
  bit          m_read;
  bit          m_dropping;   // a response is owed by memory but is already stale
  slot_t       m_parked[$];  // word held back while the pipe is stalled
  slot_t       m_ifid;
  bit          m_bubble;

  task automatic model_reset();
    m_pc       = 32'h60;
    m_redirect = 32'h0;
    m_read     = 1'b0;
    m_dropping = 1'b0;
    m_parked.delete();
    m_ifid     = '{32'h0, 32'h13};
    m_bubble   = 1'b1;
  endtask

  task automatic model_step(input logic st, input logic mis, input logic [31:0] ex,
                            input logic sbp, input logic [31:0] sbpt,
                            input logic resp, input logic [31:0] rdata);
    logic [31:0] target;
    target = (sbp && !m_bubble) ? sbpt : m_pc + 32'd4;
    if (mis) begin
      m_bubble = 1'b1;
      if (m_parked.size() != 0) begin
        m_parked.delete();
        m_pc = ex;
      end else if (m_dropping || !resp) begin
        m_redirect = ex;
        m_dropping = 1'b1;
        if (resp) begin
          m_pc       = ex;
          m_dropping = 1'b0;
        end
      end else begin
        m_pc = ex;
      end
    end else if (m_dropping) begin
      if (resp) begin
        m_pc       = m_redirect;
        m_dropping = 1'b0;
      end
    end else if (m_parked.size() != 0) begin
      if (!st) begin
        m_ifid   = m_parked.pop_front();
        m_bubble = 1'b0;
      end
    end else if (resp) begin
      if (st) begin
        m_parked.push_back('{m_pc, rdata});
      end else begin
        m_ifid   = '{m_pc, rdata};
        m_bubble = 1'b0;
      end
      m_pc = target;
    end else if (!st) begin
      m_bubble = 1'b1;
    end
    m_read = (m_parked.size() == 0);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom() & 32'hFFFF_FFFC;
    if ($urandom_range(0, 15) == 0) a = 32'hFFFF_FFFC;
    return a;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    fill_table();

    repeat (2) @(posedge clk);
    #1 check_outputs("reset", 1'b0, 32'h60, 32'h0, 32'h13, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].stall, vecs[i].mis, vecs[i].ex, vecs[i].sbp, vecs[i].sbpt,
            vecs[i].resp, vecs[i].rdata);
      @(posedge clk);
      #1 check_outputs($sformatf("vec%0d", i), vecs[i].e_read, vecs[i].e_addr,
                       vecs[i].e_pc, vecs[i].e_ir, vecs[i].e_inv);
    end

    // Reset while draining, then a late response right after release.
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1 check_outputs("drain_reset_async", 1'b0, 32'h60, 32'h0, 32'h13, 1'b1);
    @(posedge clk);
    #1 check_outputs("drain_reset_held", 1'b0, 32'h60, 32'h0, 32'h13, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 1, W_M);
    @(posedge clk);
    #1 check_outputs("late_resp", 1'b1, 32'h64, 32'h60, W_M, 1'b0);

    // Randomized run against the model, with occasional resets.
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        st, mis, sbp, resp;
      logic [31:0] ex, sbpt, rdata;
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        #1 check_outputs($sformatf("rnd%0d.reset", cyc), m_read, m_pc, m_ifid.pc,
                         m_ifid.ir, m_bubble);
        @(negedge clk);
        rst_n = 1'b1;
      end
      st    = ($urandom_range(0, 2) == 0);
      mis   = ($urandom_range(0, 9) == 0);
      ex    = rand_addr();
      sbp   = ($urandom_range(0, 3) == 0);
      sbpt  = rand_addr();
      resp  = m_read && ($urandom_range(0, 2) != 0);
      rdata = $urandom();
      drive(st, mis, ex, sbp, sbpt, resp, rdata);
      @(posedge clk);
      model_step(st, mis, ex, sbp, sbpt, resp, rdata);
      #1 check_outputs($sformatf("rnd%0d", cyc), m_read, m_pc, m_ifid.pc, m_ifid.ir, m_bubble);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 clk  in  1  rising-edge clock, single clock domain.
REQ-002 rst_n  in  1  reset, asynchronous, active-low.
REQ-003 stall  in  1  downstream hazard or dcache hold; IF/ID contents frozen while high.
REQ-004 mispredict  in  1  EX-stage branch resolution disagrees with prediction; flush and redirect.
REQ-005 ex_target  in  32  correct PC from EX, valid with mispredict.
REQ-006 sbp_mux_sel  in  1  ID-stage static predictor redirect request.
REQ-007 sbp_target  in  32  predictor target PC, valid with sbp_mux_sel.
REQ-008 imem_resp  in  1  instruction memory response, one-cycle pulse.
REQ-009 imem_rdata  in  32  instruction word, valid with imem_resp.
REQ-010 imem_read  out  1  fetch request; held high until imem_resp.
REQ-011 imem_address  out  32  fetch address; stable while imem_read high.
REQ-012 IF_ID_pc_out  out  32  PC of instruction in IF/ID.
REQ-013 IF_ID_ir_out  out  32  instruction word in IF/ID.
REQ-014 IF_ID_invalidate_out  out  1  IF/ID holds a bubble.
REQ-015 opcode  out  7  IF_ID_ir_out[6:0], combinational.

Function
REQ-016 States: FETCH (request outstanding), FULL (response captured in one-entry buffer, no request), DRAIN (outstanding request to be discarded).
REQ-017 imem_read SHALL be 1 in FETCH and DRAIN, 0 in FULL; imem_address SHALL equal internal pc register.
REQ-018 Accept event: imem_resp=1 in FETCH, mispredict=0.
REQ-019 On accept with stall=0: IF/ID <= {pc, imem_rdata, invalidate=0}; pc <= next PC; stay FETCH; latency one cycle resp-to-IF/ID.
REQ-020 On accept with stall=1: word and pc captured into buffer; pc <= next PC; go FULL; IF/ID unchanged.
REQ-021 Next PC priority: sbp_mux_sel=1 and IF_ID_invalidate_out=0 -> sbp_target; else pc+4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-022 FETCH, no resp, stall=0, mispredict=0: IF/ID <= bubble (invalidate=1, pc and ir unchanged).
REQ-023 FETCH, no resp, stall=1: IF/ID unchanged.
REQ-024 FULL with stall=0: buffer moves to IF/ID with invalidate=0; go FETCH next cycle with imem_read=1.
REQ-025 mispredict=1 in any state SHALL, overriding stall: set IF_ID_invalidate_out=1 next cycle; clear buffer.
REQ-026 mispredict in FETCH without resp: latch ex_target into redirect register; go DRAIN; imem_address held at old pc.
REQ-027 mispredict in FETCH with resp same cycle: discard imem_rdata; pc <= ex_target; stay FETCH.
REQ-028 mispredict in FULL: pc <= ex_target; go FETCH.
REQ-029 mispredict in DRAIN: overwrite redirect register with newest ex_target.
REQ-030 DRAIN on imem_resp: discard data; pc <= redirect register; go FETCH; IF/ID stays bubble.
REQ-031 sbp_mux_sel SHALL only affect next PC at an accept or FULL-buffer capture; ignored otherwise.
REQ-032 No instruction SHALL enter IF/ID twice or be lost while stall toggles.

Reset
REQ-033 While rst_n=0: pc=0x00000060, state FETCH, imem_read=0, IF_ID_pc_out=0, IF_ID_ir_out=0x00000013, IF_ID_invalidate_out=1, buffer empty, redirect register 0.
REQ-034 First cycle after rst_n rises: imem_read=1, imem_address=0x00000060.
REQ-035 Reset asserted mid-request or in DRAIN/FULL SHALL abandon it immediately; a late imem_resp after release SHALL be treated as a normal accept for 0x00000060.

Verification
REQ-036 Sequential: resp each cycle, words A,B from 0x60,0x64 -> IF_ID_pc_out 0x60 then 0x64, invalidate=0, imem_address 0x64 then 0x68.
REQ-037 Stall: accept 0x64 with stall=1 for 3 cycles -> IF/ID holds 0x60, imem_read=0 during FULL, 0x64 appears cycle after stall falls.
REQ-038 Predictor: IF/ID valid, sbp_mux_sel=1, sbp_target=0x100, accept -> next imem_address=0x100.
REQ-039 Mispredict with request outstanding, ex_target=0x200 -> invalidate=1, DRAIN; resp discarded; next imem_address=0x200.
REQ-040 Mispredict and stall together in FULL -> buffer dropped, invalidate=1, imem_address=ex_target.
REQ-041 Wrap: pc=0xFFFFFFFC accepted -> next imem_address=0x00000000; reset mid-DRAIN -> outputs per REQ-033.
